fp_result_viewer: RTL and testbench

Parametrised, time-multiplexed hex display controller for the FP adder result. It replaces the fixed pair of byte displays with NUM_DIGITS shared-segment digits that are scanned at a programmable refresh rate. A debounced button pulse pages through the result, and a freeze input holds the captured value. It sits between the FP adder output and the board's seven-segment, anode and LED pins.

---
 rtl/fp_display_pkg.sv | 28 ++
 rtl/hex_to_seg.sv | 11 +
 rtl/fp_result_viewer.sv | 126 ++++++++++++
 tb/tb_fp_result_viewer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_display_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// Segment patterns are active-low and ordered {a,b,c,d,e,f,g}.
package fp_display_pkg;

    localparam int SEG_W = 7;

    // All segments dark.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Ceiling log2, usable in parameter expressions; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-glyph decoder, shared by the display blocks.
module hex_to_seg
    import fp_display_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/fp_result_viewer.sv
// Time-multiplexed hex viewer for the FP adder result. The captured word is
// split into pages of NUM_DIGITS nibbles; the page is scanned one digit at a
// time, each digit lit for REFRESH_CYCLES clocks. Page 0 holds the most
// significant nibbles so sign and exponent appear first.
module fp_result_viewer
    import fp_display_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_DIGITS     = 4,
    parameter  int REFRESH_CYCLES = 50000,
    localparam int NUM_PAGES      = DATA_WIDTH / (4 * NUM_DIGITS),
    localparam int PAGE_W         = (NUM_PAGES > 1) ? clog2(NUM_PAGES) : 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  result_valid,
    input  logic                  next_page,
    input  logic                  freeze,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic [7:0]            leds,
    output logic [PAGE_W-1:0]     page
);

    localparam int DIG_W       = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int CNT_W       = clog2(REFRESH_CYCLES);
    localparam int NUM_NIBBLES = DATA_WIDTH / 4;
    localparam int NIB_W       = (NUM_NIBBLES > 1) ? clog2(NUM_NIBBLES) : 1;

    localparam logic [PAGE_W-1:0] LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [DIG_W-1:0]  LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(REFRESH_CYCLES - 1);

    logic [DATA_WIDTH-1:0] captured_q, captured_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic [DIG_W-1:0]      digitIdx_q, digitIdx_d;
    logic [CNT_W-1:0]      refreshCnt_q, refreshCnt_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [7:0]            leds_q, leds_d;

    logic [3:0]            nibbles [NUM_NIBBLES];
    logic [NIB_W-1:0]      nibIdx;
    logic [3:0]            selNibble;
    logic [SEG_W-1:0]      segPattern;

    // Capture the adder result on a strobe unless the display is frozen.
    always_comb begin
        captured_d = captured_q;
        if (result_valid && !freeze) begin
            captured_d = result;
        end
    end

    // Page advance on the debounced pulse; freeze does not block paging.
    always_comb begin
        page_d = page_q;
        if (next_page) begin
            page_d = (page_q == LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
        end
    end

    // Refresh timer and digit scan; independent of data and page changes.
    always_comb begin
        refreshCnt_d = refreshCnt_q + CNT_W'(1);
        digitIdx_d   = digitIdx_q;
        if (refreshCnt_q == LAST_COUNT) begin
            refreshCnt_d = '0;
            digitIdx_d   = (digitIdx_q == LAST_DIGIT) ? '0 : digitIdx_q + DIG_W'(1);
        end
    end

    // Nibble view of the captured word, index 0 being the most significant.
    always_comb begin
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            nibbles[i] = captured_q[DATA_WIDTH-1-4*i -: 4];
        end
    end

    // Pick the nibble for the current page and digit.
    always_comb begin
        nibIdx    = NIB_W'(int'(page_q) * NUM_DIGITS + int'(digitIdx_q));
        selNibble = nibbles[nibIdx];
    end

    hex_to_seg u_hexToSeg (
        .nibble_i (selNibble),
        .seg_o    (segPattern)
    );

    // Next values for the registered pin drivers.
    always_comb begin
        an_d   = ~(NUM_DIGITS'(1) << digitIdx_q);
        seg_d  = segPattern;
        leds_d = captured_q[7:0];
    end

    // State and pin registers; reset leaves the display dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured_q   <= '0;
            page_q       <= '0;
            digitIdx_q   <= '0;
            refreshCnt_q <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            leds_q       <= '0;
        end else begin
            captured_q   <= captured_d;
            page_q       <= page_d;
            digitIdx_q   <= digitIdx_d;
            refreshCnt_q <= refreshCnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            leds_q       <= leds_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign leds = leds_q;
    assign page = page_q;

endmodule

// File: tb/tb_fp_result_viewer.sv
// Bench for fp_result_viewer: a 4-digit instance (two pages) and an 8-digit
// instance (single page) share all inputs. Expected scan samples are queued
// when stimulus is applied and popped as the display scans.
module tb_fp_result_viewer;

    localparam int RC = 4;

    // Reference glyph table, abcdefg active-low.
    localparam logic [6:0] HEX_SEG_TB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic [31:0] result;
        logic        valid;
        logic        freeze;
        logic        nextPage;
        logic [0:0]  expPage;
        logic [15:0] expDigits;
        logic [7:0]  expLeds;
        string       name;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
    } scanExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] result;
    logic        resultValid;
    logic        nextPage;
    logic        freeze;

    logic [3:0]  an4;
    logic [6:0]  seg4;
    logic [7:0]  leds4;
    logic [0:0]  page4;
    logic [7:0]  an8;
    logic [6:0]  seg8;
    logic [7:0]  leds8;
    logic [0:0]  page8;

    int assertCount = 0;
    int failCount   = 0;

    vec_t     vecs [7];
    scanExp_t expQ [$];

    always #5 clk = ~clk;

    fp_result_viewer #(.DATA_WIDTH(32), .NUM_DIGITS(4), .REFRESH_CYCLES(RC)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_valid (resultValid),
        .next_page    (nextPage),
        .freeze       (freeze),
        .an           (an4),
        .seg          (seg4),
        .leds         (leds4),
        .page         (page4)
    );

    fp_result_viewer #(.DATA_WIDTH(32), .NUM_DIGITS(8), .REFRESH_CYCLES(RC)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_valid (resultValid),
        .next_page    (nextPage),
        .freeze       (freeze),
        .an           (an8),
        .seg          (seg8),
        .leds         (leds8),
        .page         (page8)
    );

    // Runaway guard so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] anMask(input int nd, input int d);
        logic [7:0] oneHot;
        logic [7:0] used;
        oneHot = 8'd1 << d;
        used   = (nd == 8) ? 8'hFF : 8'h0F;
        return ~oneHot & used;
    endfunction

    function automatic logic [7:0] curAn(input int nd);
        return (nd == 8) ? an8 : {4'h0, an4};
    endfunction

    function automatic logic [6:0] curSeg(input int nd);
        return (nd == 8) ? seg8 : seg4;
    endfunction

    // Queue one full scan of expected anode/segment samples, RC per digit.
    task automatic pushScan(input int nd, input logic [31:0] digits);
        logic [3:0] nib;
        for (int d = 0; d < nd; d++) begin
            nib = digits[4*(nd-1-d) +: 4];
            for (int r = 0; r < RC; r++) begin
                expQ.push_back('{anMask(nd, d), HEX_SEG_TB[nib]});
            end
        end
    endtask

    // Align to the start of digit 0, then compare one full scan against the queue.
    task automatic scanCheck(input string name, input int nd);
        int       guard;
        scanExp_t e;
        guard = 0;
        while (curAn(nd) !== anMask(nd, nd-1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (curAn(nd) !== anMask(nd, 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s/sync: no scan start within 200 cycles, an=0x%0h", name, curAn(nd));
            expQ.delete();
            return;
        end
        for (int i = 0; i < nd*RC; i++) begin
            e = expQ.pop_front();
            checkOutput($sformatf("%s/an_d%0d", name, i/RC), 32'(curAn(nd)), 32'(e.an));
            checkOutput($sformatf("%s/seg_d%0d", name, i/RC), 32'(curSeg(nd)), 32'(e.seg));
            if (i != nd*RC-1) @(negedge clk);
        end
    endtask

    // Drive one vector for a single clock, then return inputs to idle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        result      = v.result;
        resultValid = v.valid;
        freeze      = v.freeze;
        nextPage    = v.nextPage;
        @(negedge clk);
        resultValid = 1'b0;
        freeze      = 1'b0;
        nextPage    = 1'b0;
    endtask

    initial begin
        bit found;

        vecs[0] = '{32'h40490FDB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4049, 8'hDB, "capture"};
        vecs[1] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0FDB, 8'hDB, "page1"};
        vecs[2] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4049, 8'hDB, "pageWrap"};
        vecs[3] = '{32'hC0000000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4049, 8'hDB, "frozen"};
        vecs[4] = '{32'hC0000000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC000, 8'h00, "unfrozen"};
        vecs[5] = '{32'h3F800000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, "simult"};
        vecs[6] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3F80, 8'h00, "simultBack"};

        reset       = 1'b1;
        result      = '0;
        resultValid = 1'b0;
        nextPage    = 1'b0;
        freeze      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset/an4", 32'(an4), 32'h0000000F);
        checkOutput("reset/seg4", 32'(seg4), 32'h0000007F);
        checkOutput("reset/leds4", 32'(leds4), 32'h0);
        checkOutput("reset/page4", 32'(page4), 32'h0);
        checkOutput("reset/an8", 32'(an8), 32'h000000FF);

        reset = 1'b0;
        @(negedge clk);
        checkOutput("firstEdge/an4", 32'(an4), 32'h0000000E);
        checkOutput("firstEdge/seg4", 32'(seg4), 32'h00000001);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v]);
            checkOutput({vecs[v].name, "/page"}, 32'(page4), 32'(vecs[v].expPage));
            pushScan(4, {16'h0, vecs[v].expDigits});
            scanCheck(vecs[v].name, 4);
            checkOutput({vecs[v].name, "/leds"}, 32'(leds4), 32'(vecs[v].expLeds));
            if (v == 0) begin
                pushScan(8, 32'h40490FDB);
                scanCheck("sweep8", 8);
                checkOutput("sweep8/leds", 32'(leds8), 32'h000000DB);
            end
            if (v == 1) begin
                checkOutput("sweep8/pageStays0", 32'(page8), 32'h0);
            end
        end

        // Capture in the middle of digit 1: one old load, then new data, same digit.
        found = 1'b0;
        for (int g = 0; g < 200 && !found; g++) begin
            @(negedge clk);
            if (an4 === 4'b1110) found = 1'b1;
        end
        for (int g = 0; g < 200 && found && an4 !== 4'b1101; g++) begin
            @(negedge clk);
        end
        if (!found || an4 !== 4'b1101) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL midScan/sync: digit 1 never reached, an=0x%0h", an4);
        end else begin
            result      = 32'h12345678;
            resultValid = 1'b1;
            @(negedge clk);
            resultValid = 1'b0;
            checkOutput("midScan/oldAn", 32'(an4), 32'h0000000D);
            checkOutput("midScan/oldSeg", 32'(seg4), 32'(HEX_SEG_TB[15]));
            @(negedge clk);
            checkOutput("midScan/newAn", 32'(an4), 32'h0000000D);
            checkOutput("midScan/newSeg", 32'(seg4), 32'(HEX_SEG_TB[2]));
            checkOutput("midScan/leds", 32'(leds4), 32'h00000078);
        end

        // Move to page 1, then hit reset between clock edges.
        @(negedge clk);
        nextPage = 1'b1;
        @(negedge clk);
        nextPage = 1'b0;
        checkOutput("preReset/page4", 32'(page4), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset/an4", 32'(an4), 32'h0000000F);
        checkOutput("asyncReset/seg4", 32'(seg4), 32'h0000007F);
        checkOutput("asyncReset/leds4", 32'(leds4), 32'h0);
        checkOutput("asyncReset/page4", 32'(page4), 32'h0);
        checkOutput("asyncReset/an8", 32'(an8), 32'h000000FF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("afterReset/an4", 32'(an4), 32'h0000000E);
        checkOutput("afterReset/seg4", 32'(seg4), 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
